// File: rtl/sierpinski_lfsr_checker.sv
// Receive-side checker for the 14-bit Sierpinski LFSR stream (taps 13,12,11,1).
// It rebuilds the generator state from the received bits, locks, then flags and counts bit errors.
module sierpinski_lfsr_checker #(
  parameter int LOCK_COUNT = 14,
  parameter int ERR_THRESH = 4,
  parameter int WINDOW     = 64,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 clear_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 zero_seen
);

  localparam int SR_W   = 14;
  localparam int FILL_W = $clog2(SR_W + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WERR_W = $clog2(ERR_THRESH + 1);

  typedef enum logic [1:0] {S_FILL, S_VERIFY, S_LOCKED} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SR_W-1:0]       r_sr;
  logic [SR_W-1:0]       w_sr_nxt;
  logic [FILL_W-1:0]     r_fill_cnt;
  logic [GOOD_W-1:0]     r_good_cnt;
  logic [WIN_W-1:0]      r_win_cnt;
  logic [WERR_W-1:0]     r_win_err;
  logic [WERR_W-1:0]     w_win_err_nxt;
  logic                  r_locked;
  logic                  r_err_pulse;
  logic [ERR_CNT_W-1:0]  r_err_count;
  logic                  r_zero_seen;

  logic                  w_exp;
  logic                  w_match;
  logic                  w_sr_zero;
  logic                  w_err;
  logic                  w_fill_done;
  logic                  w_good_hit;
  logic                  w_win_wrap;
  logic                  w_thresh;
  logic                  w_locked_nxt;
  logic                  w_pulse_nxt;
  logic                  w_zero_nxt;
  logic [ERR_CNT_W-1:0]  w_cnt_nxt;

  // Prediction always uses the pre-shift register contents.
  assign w_exp       = r_sr[13] ^ r_sr[12] ^ r_sr[11] ^ r_sr[1];
  assign w_match     = (bit_in == w_exp);
  assign w_sr_zero   = (r_sr == '0);
  assign w_err       = bit_valid && (r_state == S_LOCKED) && !w_match;
  assign w_fill_done = bit_valid && (r_state == S_FILL) && (r_fill_cnt == FILL_W'(SR_W - 1));
  assign w_good_hit  = bit_valid && (r_state == S_VERIFY) && !w_sr_zero && w_match &&
                       (r_good_cnt == GOOD_W'(LOCK_COUNT - 1));
  assign w_win_wrap  = (r_win_cnt == WIN_W'(WINDOW - 1));
  // An error on the wrap bit is the first error of the new window.
  assign w_win_err_nxt = w_win_wrap ? WERR_W'(w_err) : (r_win_err + WERR_W'(w_err));
  assign w_thresh    = w_err && (w_win_err_nxt == WERR_W'(ERR_THRESH));

  // Once locked the reference free-runs, so a flipped bit cannot corrupt later predictions.
  always_comb begin
    w_sr_nxt = r_sr;
    if (bit_valid) begin
      w_sr_nxt = {r_sr[SR_W-2:0], (r_state == S_LOCKED) ? w_exp : bit_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:   if (w_fill_done) w_state_nxt = S_VERIFY;
      S_VERIFY: if (w_good_hit)  w_state_nxt = S_LOCKED;
      S_LOCKED: if (w_thresh)    w_state_nxt = S_FILL;
      default:                   w_state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    w_locked_nxt = (w_state_nxt == S_LOCKED);
    w_pulse_nxt  = w_err;
    w_zero_nxt   = r_zero_seen;
    if (bit_valid) begin
      w_zero_nxt = (w_sr_nxt == '0) && (w_state_nxt != S_LOCKED);
    end
    w_cnt_nxt = r_err_count;
    if (clear_cnt) begin
      w_cnt_nxt = w_err ? ERR_CNT_W'(1) : '0;
    end else if (w_err && (r_err_count != '1)) begin
      w_cnt_nxt = r_err_count + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr       <= '0;
      r_fill_cnt <= '0;
      r_good_cnt <= '0;
      r_win_cnt  <= '0;
      r_win_err  <= '0;
    end else begin
      r_sr <= w_sr_nxt;
      if (bit_valid) begin
        case (r_state)
          S_FILL: begin
            if (w_fill_done) begin
              r_fill_cnt <= '0;
              r_good_cnt <= '0;
            end else begin
              r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            end
          end
          S_VERIFY: begin
            if (w_sr_zero || !w_match) begin
              r_good_cnt <= '0;
            end else if (w_good_hit) begin
              r_good_cnt <= '0;
              r_win_cnt  <= '0;
              r_win_err  <= '0;
            end else begin
              r_good_cnt <= r_good_cnt + GOOD_W'(1);
            end
          end
          S_LOCKED: begin
            r_win_cnt <= w_win_wrap ? '0 : (r_win_cnt + WIN_W'(1));
            if (w_thresh) begin
              r_win_err  <= '0;
              r_fill_cnt <= '0;
            end else begin
              r_win_err <= w_win_err_nxt;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_zero_seen <= 1'b0;
    end else begin
      r_locked    <= w_locked_nxt;
      r_err_pulse <= w_pulse_nxt;
      r_err_count <= w_cnt_nxt;
      r_zero_seen <= w_zero_nxt;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign zero_seen = r_zero_seen;

endmodule
